// File: rtl/fifosc_reader.sv
// Read-side adapter for a 1-cycle-latency fifosc: issues removes, captures the
// returned words into a 3-entry skid buffer and presents them as a valid/ready stream.
module fifosc_reader #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_remove,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [15:0]           beat_count
);

  logic [DATA_WIDTH-1:0] buf_r [0:2];
  logic [1:0]            head_r;
  logic [1:0]            tail_r;
  logic [1:0]            occ_r;
  logic                  inflight_r;
  logic [15:0]           beat_count_r;

  logic [2:0]            pending_s;
  logic                  push_s;
  logic                  pop_s;
  logic [1:0]            occ_next_s;
  logic [DATA_WIDTH-1:0] head_data_s;

  // Pointer advance modulo 3.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    logic [1:0] nxt;
    case (ptr)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Remove strobe: counts the inflight word as occupied so it always has a slot to land in.
  always_comb begin
    pending_s   = {1'b0, occ_r} + {2'b00, inflight_r};
    fifo_remove = enable & ~flush & ~fifo_empty & (pending_s < 3'd3);
  end

  // Buffer push/pop decode and head-word mux.
  always_comb begin
    push_s = inflight_r;
    pop_s  = (occ_r != 2'd0) & m_ready;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + 2'd1;
      2'b01:   occ_next_s = occ_r - 2'd1;
      default: occ_next_s = occ_r;
    endcase
    case (head_r)
      2'd0:    head_data_s = buf_r[0];
      2'd1:    head_data_s = buf_r[1];
      2'd2:    head_data_s = buf_r[2];
      default: head_data_s = buf_r[0];
    endcase
  end

  // Skid buffer, pointers, inflight flag and beat counter; flush overrides everything.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < 3; i++) begin
        buf_r[i] <= '0;
      end
      head_r       <= 2'd0;
      tail_r       <= 2'd0;
      occ_r        <= 2'd0;
      inflight_r   <= 1'b0;
      beat_count_r <= 16'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push_s && (tail_r == 2'(i))) begin
          buf_r[i] <= fifo_dout;
        end
      end
      if (push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r       <= ptr_inc(head_r);
        beat_count_r <= beat_count_r + 16'd1;
      end
      occ_r      <= occ_next_s;
      inflight_r <= fifo_remove;
    end
  end

  assign m_valid    = (occ_r != 2'd0);
  assign m_data     = head_data_s;
  assign beat_count = beat_count_r;

endmodule

// File: doc/fifosc_reader.md
FIFOSC_READER -- requirements
Module: fifosc_reader

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 4, data word width in bits; all data ports use it.

Interface
REQ-002 SHALL have clk  input  1  posedge clock; the single clock for all state.
REQ-003 SHALL have flush  input  1  reset, synchronous and active-high; the same net drives the upstream fifosc flush.
REQ-004 SHALL have enable  input  1  permits new FIFO reads when high.
REQ-005 SHALL have fifo_empty  input  1  empty flag from the upstream fifosc.
REQ-006 SHALL have fifo_dout  input  DATA_WIDTH  registered read data from the upstream fifosc.
REQ-007 SHALL have fifo_remove  output  1  remove strobe to the upstream fifosc.
REQ-008 SHALL have m_valid  output  1  output stream word valid.
REQ-009 SHALL have m_ready  input  1  downstream accepts the word.
REQ-010 SHALL have m_data  output  DATA_WIDTH  output stream word.
REQ-011 SHALL have beat_count  output  16  count of delivered beats.

Function
REQ-012 SHALL hold a local 3-entry FIFO buffer with occupancy occ (0..3).
REQ-013 SHALL hold a 1-bit inflight register: fifo_remove registered at each edge.
REQ-014 SHALL compute fifo_remove combinationally, from registers and fifo_empty only: enable & ~flush & ~fifo_empty & (occ + inflight < 3).
REQ-015 SHALL have no combinational path from m_ready to fifo_remove.
REQ-016 SHALL treat fifo_dout as valid in the cycle after fifo_remove was high, since read latency is 1 cycle.
REQ-017 SHALL, on the edge ending a cycle with inflight=1, write fifo_dout into the buffer tail.
REQ-018 SHALL drive m_valid = (occ != 0), and SHALL drive m_data from the buffer head.
REQ-019 SHALL complete a beat on an edge where m_valid & m_ready; the head is then popped.
REQ-020 SHALL, on a simultaneous capture and pop in one edge, leave occ unchanged and preserve order.
REQ-021 SHALL hold m_data and m_valid stable while m_valid & ~m_ready.
REQ-022 SHALL ensure occ + inflight never exceeds 3, so no captured word is ever dropped.
REQ-023 SHALL, when enable falls, issue no new removes; an inflight word still lands and buffered words still drain.
REQ-024 SHALL sustain 1 beat/clk when the upstream FIFO is non-empty and m_ready stays high: steady state occ=1, inflight=1.
REQ-025 SHALL increment beat_count by 1 on each completed beat, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL keep data order identical to upstream FIFO read order.
REQ-027 SHALL handle buffer pointer wrap modulo 3.
REQ-028 SHALL leave m_data and buffer contents don't-care when occ=0; the bench checks m_data only when m_valid=1.

Reset
REQ-029 SHALL, on any edge with flush=1, set occ=0, inflight=0, m_valid=0, m_data=0, beat_count=0 and both buffer pointers=0.
REQ-030 SHALL force fifo_remove=0 while flush=1.
REQ-031 SHALL discard an inflight word when flush occurs mid-operation; no capture follows.
REQ-032 SHALL place the first fifo_remove no earlier than the first cycle after flush deasserts.
REQ-033 SHALL take flush priority over enable, m_ready, and every capture and pop.

Verification
REQ-034 Basic drain: upstream loaded with 0x1,0x2,0x3; enable=1, m_ready=1 -> m_data 1,2,3 on consecutive beats; first m_valid 2 cycles after the first remove; beat_count=3.
REQ-035 Backpressure: upstream holds 6 words, m_ready=0 -> exactly 3 removes issued, occ=3, m_valid=1, m_data stable = word 0. Then m_ready=1 -> all 6 words delivered in order, none lost or duplicated.
REQ-036 Streaming: upstream continuously non-empty, m_ready=1 for 20 cycles -> after 2 fill cycles, m_valid=1 every cycle and beat_count advances by 1 every clk.
REQ-037 Enable gate: enable dropped the cycle after a remove -> that word is still delivered, then no further fifo_remove until enable=1.
REQ-038 Mid-op flush: flush asserted with inflight=1 and occ=2 -> next cycle m_valid=0, beat_count=0, fifo_remove=0; the old word never appears.
REQ-039 Counter wrap: beat_count preloaded near 0xFFFF via 0xFFFF beats, one more beat -> beat_count=0x0000.
